// File: rtl/uaz_core_pkg.sv
// Shared encodings for the UAZ core: opcodes, jump conditions, sequencer states.
// Instruction word layout: [8:6] cond/field A, [5:3] RX, [2:0] opcode.
package uaz_core_pkg;

  localparam logic [2:0] OP_LOAD_IMM  = 3'b000;
  localparam logic [2:0] OP_LOAD_IND  = 3'b001;
  localparam logic [2:0] OP_STORE_IMM = 3'b010;
  localparam logic [2:0] OP_STORE_IND = 3'b011;
  localparam logic [2:0] OP_MOVE      = 3'b100;
  localparam logic [2:0] OP_MATH      = 3'b101;
  localparam logic [2:0] OP_JUMP      = 3'b110;
  localparam logic [2:0] OP_NOP       = 3'b111;

  localparam logic [2:0] COND_ALWAYS      = 3'd0;
  localparam logic [2:0] COND_ALWAYS_LINK = 3'd1;
  localparam logic [2:0] COND_Z           = 3'd2;
  localparam logic [2:0] COND_NOT_Z       = 3'd3;
  localparam logic [2:0] COND_C           = 3'd4;
  localparam logic [2:0] COND_NOT_C       = 3'd5;
  localparam logic [2:0] COND_N           = 3'd6;
  localparam logic [2:0] COND_NOT_N       = 3'd7;

  localparam logic [8:0] NOP_WORD = 9'b111_000_111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_LINK  = 2'd3
  } seq_state_e;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[2:0];
  endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump-condition resolver: maps a 3-bit condition and the
// latched Z/C/N flags to a taken decision.
module jump_cond_eval
  import uaz_core_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       c,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS, COND_ALWAYS_LINK: taken = 1'b1;
      COND_Z:     taken = z;
      COND_NOT_Z: taken = ~z;
      COND_C:     taken = c;
      COND_NOT_C: taken = ~c;
      COND_N:     taken = n;
      COND_NOT_N: taken = ~n;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute controller for the UAZ core: owns PC and IR, handshakes with ROM.
// SEQ_JUMP_LINK_EN enables the jump-and-link state (cond 1); otherwise cond 1 is a plain jump.
module instruction_sequencer
  import uaz_core_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                ROM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rom_ack,
  input  logic [8:0]        Rom_data,
  output logic              Rom_req,
  output logic [ADDR_W-1:0] PC,
  output logic [8:0]        Instruction,
  input  logic [ADDR_W-1:0] Jump_addr,
  input  logic              Flag_Z,
  input  logic              Flag_C,
  input  logic              Flag_N,
  output logic              Exec,
  output logic              Flag_we,
  output logic              Link_we,
  output logic [ADDR_W-1:0] Link_data,
  output logic              Fault
);

  localparam int TMO_W = $clog2(ROM_TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic              rom_req_q, rom_req_d;
  logic              exec_q, exec_d;
  logic              flag_we_q, flag_we_d;
  logic              fault_q, fault_d;
  logic              z_q, z_d, c_q, c_d, n_q, n_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              taken;
  logic [ADDR_W-1:0] pc_inc;
`ifdef SEQ_JUMP_LINK_EN
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
`endif

  assign pc_inc = pc_q + 1'b1;

  jump_cond_eval u_jump_cond_eval (
    .cond  (ir_q[8:6]),
    .z     (z_q),
    .c     (c_q),
    .n     (n_q),
    .taken (taken)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rom_req_d = rom_req_q;
    exec_d    = 1'b0;
    flag_we_d = 1'b0;
    fault_d   = fault_q;
    z_d       = z_q;
    c_d       = c_q;
    n_d       = n_q;
    tmo_d     = tmo_q;
`ifdef SEQ_JUMP_LINK_EN
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
`endif
    case (state_q)
      ST_FETCH: begin
        rom_req_d = 1'b1;
        tmo_d     = TMO_W'(ROM_TIMEOUT - 1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (Rom_ack) begin
          ir_d      = Rom_data;
          rom_req_d = 1'b0;
          exec_d    = (opcode_of(Rom_data) != OP_NOP);
          flag_we_d = (opcode_of(Rom_data) == OP_MATH);
          state_d   = ST_EXEC;
        end else if (tmo_q == '0) begin
          // Timeout is reported but the fetch keeps waiting for the ROM.
          fault_d = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_EXEC: begin
        pc_d    = pc_inc;
        state_d = ST_FETCH;
        if (opcode_of(ir_q) == OP_MATH) begin
          z_d = Flag_Z;
          c_d = Flag_C;
          n_d = Flag_N;
        end
        if (opcode_of(ir_q) == OP_JUMP) begin
          if (taken) pc_d = Jump_addr;
`ifdef SEQ_JUMP_LINK_EN
          if (ir_q[8:6] == COND_ALWAYS_LINK) begin
            link_we_d   = 1'b1;
            link_data_d = pc_inc;
            state_d     = ST_LINK;
          end
`endif
        end
      end
      ST_LINK:  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_WORD;
      rom_req_q <= 1'b0;
      exec_q    <= 1'b0;
      flag_we_q <= 1'b0;
      fault_q   <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      tmo_q     <= '0;
`ifdef SEQ_JUMP_LINK_EN
      link_we_q   <= 1'b0;
      link_data_q <= RESET_PC + 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rom_req_q <= rom_req_d;
      exec_q    <= exec_d;
      flag_we_q <= flag_we_d;
      fault_q   <= fault_d;
      z_q       <= z_d;
      c_q       <= c_d;
      n_q       <= n_d;
      tmo_q     <= tmo_d;
`ifdef SEQ_JUMP_LINK_EN
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
`endif
    end
  end

  assign Rom_req     = rom_req_q;
  assign PC          = pc_q;
  assign Instruction = ir_q;
  assign Exec        = exec_q;
  assign Flag_we     = flag_we_q;
  assign Fault       = fault_q;
`ifdef SEQ_JUMP_LINK_EN
  assign Link_we     = link_we_q;
  assign Link_data   = link_data_q;
`else
  assign Link_we     = 1'b0;
  assign Link_data   = '0;
`endif

endmodule
